// File: rtl/lock_countdown_pkg.sv
// Shared display package for lock_countdown: FSM states, BCD helpers and seven-segment table.
package lock_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Active-high segments packed as {dp, g, f, e, d, c, b, a}; non-decimal codes blank.
    function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
        case (digit)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= BCD_MAX[7:4]) && (v[3:0] <= BCD_MAX[3:0]);
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/lock_countdown_seg_decode.sv
// Purely combinational BCD digit to seven-segment pattern converter.
module seg_decode
    import lock_countdown_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = seg_pattern(i_digit);
    end

endmodule

// File: rtl/lock_countdown.sv
// Two-digit BCD seconds countdown with seven-segment outputs.
// Optional blink of the last ten seconds: define LOCK_COUNTDOWN_BLINK_EN.
module lock_countdown
    import lock_countdown_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 12_000_000,
    parameter logic [7:0]  DEFAULT_SEC = 8'h60
) (
    input  logic       clkI,
    input  logic       rstnI,
    input  logic       startI,
    input  logic [7:0] secI,
    input  logic       abortI,
    output logic       busyO,
    output logic       doneO,
    output logic [7:0] segO1,
    output logic [7:0] segO2,
    output logic [1:0] segDig
);

    localparam int unsigned    PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_val;
    logic [7:0]       w_next_val;
    logic [7:0]       w_load;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_next_pre;
    logic [7:0]       w_seg_tens;
    logic [7:0]       w_seg_units;
    logic [1:0]       w_dig;

    assign w_load = bcd_valid(secI) ? secI : DEFAULT_SEC;

    always_comb begin
        w_next_state = r_state;
        w_next_val   = r_val;
        w_next_pre   = r_pre;
        case (r_state)
            IDLE: begin
                if (startI) begin
                    w_next_val   = w_load;
                    w_next_pre   = '0;
                    w_next_state = (w_load == 8'h00) ? EXPIRE : COUNT;
                end
            end
            COUNT: begin
                if (abortI) begin
                    w_next_state = IDLE;
                    w_next_val   = '0;
                    w_next_pre   = '0;
                end else if (startI) begin
                    w_next_val = w_load;
                    w_next_pre = '0;
                end else if (r_pre == PRE_MAX) begin
                    w_next_pre = '0;
                    // A value already at 00 (reload of 00 mid-count) also expires here.
                    if (r_val <= 8'h01) begin
                        w_next_val   = '0;
                        w_next_state = EXPIRE;
                    end else begin
                        w_next_val = bcd_dec(r_val);
                    end
                end else begin
                    w_next_pre = r_pre + 1'b1;
                end
            end
            EXPIRE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_val   = '0;
                w_next_pre   = '0;
            end
        endcase
    end

`ifdef LOCK_COUNTDOWN_BLINK_EN
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2);
    assign w_dig = ((w_next_val <= 8'h09) && (w_next_pre >= PRE_HALF)) ? 2'b11 : 2'b00;
`else
    assign w_dig = 2'b00;
`endif

    seg_decode u_dec_tens  (.i_digit(w_next_val[7:4]), .o_seg(w_seg_tens));
    seg_decode u_dec_units (.i_digit(w_next_val[3:0]), .o_seg(w_seg_units));

    // Outputs are registered from next-state values so the display tracks the state with no lag.
    always_ff @(posedge clkI or negedge rstnI) begin
        if (!rstnI) begin
            r_state <= IDLE;
            r_val   <= '0;
            r_pre   <= '0;
            busyO   <= 1'b0;
            doneO   <= 1'b0;
            segDig  <= 2'b11;
            segO1   <= seg_pattern(4'd0);
            segO2   <= seg_pattern(4'd0);
        end else begin
            r_state <= w_next_state;
            r_val   <= w_next_val;
            r_pre   <= w_next_pre;
            busyO   <= (w_next_state == COUNT);
            doneO   <= (w_next_state == EXPIRE);
            if (w_next_state == COUNT) begin
                segDig <= w_dig;
                segO1  <= w_seg_tens;
                segO2  <= w_seg_units;
            end else begin
                segDig <= 2'b11;
                segO1  <= seg_pattern(4'd0);
                segO2  <= seg_pattern(4'd0);
            end
        end
    end

endmodule

// File: tb/tb_lock_countdown.sv
// Self-checking bench for lock_countdown (CLK_HZ=10) against a decimal-seconds reference model.
module tb_lock_countdown;

    localparam int CLK_HZ = 10;
`ifdef LOCK_COUNTDOWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clkI = 1'b0;
    logic       rstnI = 1'b0;
    logic       startI = 1'b0;
    logic [7:0] secI = 8'h00;
    logic       abortI = 1'b0;
    logic       busyO;
    logic       doneO;
    logic [7:0] segO1;
    logic [7:0] segO2;
    logic [1:0] segDig;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0=idle 1=counting 2=expired, seconds as a plain integer.
    int m_mode = 0;
    int m_secs = 0;
    int m_cyc  = 0;

    lock_countdown #(.CLK_HZ(CLK_HZ), .DEFAULT_SEC(8'h60)) dut (
        .clkI(clkI), .rstnI(rstnI), .startI(startI), .secI(secI), .abortI(abortI),
        .busyO(busyO), .doneO(doneO), .segO1(segO1), .segO2(segO2), .segDig(segDig)
    );

    always #5 clkI = ~clkI;

    function automatic logic [7:0] pat(input int d);
        case (d)
            0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
            4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
            8: return 8'h7F; 9: return 8'h6F; default: return 8'h00;
        endcase
    endfunction

    function automatic int load_of(input logic [7:0] s);
        if (s[7:4] > 4'd9 || s[3:0] > 4'd9) return 60;
        return int'(s[7:4]) * 10 + int'(s[3:0]);
    endfunction

    function automatic logic [1:0] exp_dig();
        if (m_mode != 1) return 2'b11;
        if (BLINK && m_secs <= 9 && m_cyc >= CLK_HZ / 2) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_secs = 0; m_cyc = 0;
    endtask

    task automatic model_edge(input bit s, input logic [7:0] v, input bit a);
        if (!rstnI) begin
            model_reset();
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (s) begin
                m_secs = load_of(v); m_cyc = 0;
                m_mode = (m_secs == 0) ? 2 : 1;
            end
        end else if (a) begin
            model_reset();
        end else if (s) begin
            m_secs = load_of(v); m_cyc = 0;
        end else begin
            m_cyc++;
            if (m_cyc == CLK_HZ) begin
                m_cyc = 0;
                m_secs--;
                if (m_secs <= 0) begin m_secs = 0; m_mode = 2; end
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, leave time at edge+1.
    task automatic tick(input bit s, input logic [7:0] v, input bit a);
        startI = s; secI = v; abortI = a;
        @(posedge clkI);
        model_edge(s, v, a);
        #1;
        startI = 1'b0; abortI = 1'b0;
    endtask

    task automatic test_reset();
        rstnI = 1'b0;
        repeat (3) @(posedge clkI);
        #1;
        model_reset();
        n_checks++; if (busyO !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busyO); end
        n_checks++; if (doneO !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", doneO); end
        n_checks++; if (segDig !== 2'b11) begin n_fail++; $display("FAIL reset_segDig got=%b want=11", segDig); end
        n_checks++; if (segO1 !== pat(0) || segO2 !== pat(0)) begin
            n_fail++; $display("FAIL reset_seg got=%h/%h want=%h/%h", segO1, segO2, pat(0), pat(0)); end
        @(negedge clkI);
        rstnI = 1'b1;
    endtask

    task automatic test_countdown();
        int n;
        bit seen;
        tick(1'b1, 8'h03, 1'b0);
        n_checks++; if (busyO !== 1'b1) begin n_fail++; $display("FAIL cd_busy got=%b want=1", busyO); end
        n_checks++; if (segO1 !== pat(0) || segO2 !== pat(3) || segDig !== exp_dig()) begin
            n_fail++; $display("FAIL cd_show03 got=%h/%h/%b want=%h/%h/%b", segO1, segO2, segDig, pat(0), pat(3), exp_dig()); end
        n = 0; seen = 0;
        while (!seen && n < 100) begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
            if (n == 10) begin
                n_checks++; if (segO2 !== pat(2)) begin n_fail++; $display("FAIL cd_show02 got=%h want=%h", segO2, pat(2)); end
            end
            if (n == 20) begin
                n_checks++; if (segO2 !== pat(1)) begin n_fail++; $display("FAIL cd_show01 got=%h want=%h", segO2, pat(1)); end
            end
            if (doneO === 1'b1) seen = 1;
        end
        n_checks++; if (!seen || n != 30) begin n_fail++; $display("FAIL cd_done_latency got=%0d seen=%0d want=30", n, seen); end
        n_checks++; if (busyO !== 1'b0) begin n_fail++; $display("FAIL cd_expire_busy got=%b want=0", busyO); end
        tick(1'b0, 8'h00, 1'b0);
        n_checks++; if (doneO !== 1'b0 || segDig !== 2'b11) begin
            n_fail++; $display("FAIL cd_back_idle got done=%b dig=%b want done=0 dig=11", doneO, segDig); end
    endtask

    task automatic test_borrow();
        tick(1'b1, 8'h10, 1'b0);
        repeat (CLK_HZ) tick(1'b0, 8'h00, 1'b0);
        n_checks++; if (segO1 !== pat(0) || segO2 !== pat(9)) begin
            n_fail++; $display("FAIL borrow got=%h/%h want=%h/%h", segO1, segO2, pat(0), pat(9)); end
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_invalid();
        logic [7:0] bad [3] = '{8'hA5, 8'h3C, 8'hFF};
        foreach (bad[i]) begin
            tick(1'b1, bad[i], 1'b0);
            n_checks++; if (segO1 !== pat(6) || segO2 !== pat(0) || busyO !== 1'b1) begin
                n_fail++; $display("FAIL invalid_%h got=%h/%h busy=%b want=%h/%h busy=1", bad[i], segO1, segO2, busyO, pat(6), pat(0)); end
            tick(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_zero();
        bit rose;
        tick(1'b1, 8'h00, 1'b0);
        n_checks++; if (doneO !== 1'b1 || busyO !== 1'b0) begin
            n_fail++; $display("FAIL zero_done got done=%b busy=%b want done=1 busy=0", doneO, busyO); end
        rose = 0;
        repeat (5) begin
            tick(1'b0, 8'h00, 1'b0);
            if (busyO !== 1'b0 || doneO !== 1'b0) rose = 1;
        end
        n_checks++; if (rose) begin n_fail++; $display("FAIL zero_after got busy/done activity=1 want=0"); end
    endtask

    task automatic test_abort();
        bit bad_done;
        int n;
        tick(1'b1, 8'h05, 1'b0);
        repeat (3) tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b1);
        n_checks++; if (busyO !== 1'b0 || segDig !== 2'b11 || doneO !== 1'b0) begin
            n_fail++; $display("FAIL abort got busy=%b dig=%b done=%b want 0/11/0", busyO, segDig, doneO); end
        tick(1'b1, 8'h05, 1'b0);
        repeat (4) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h07, 1'b1);
        n_checks++; if (busyO !== 1'b0 || segDig !== 2'b11 || doneO !== 1'b0) begin
            n_fail++; $display("FAIL abort_start got busy=%b dig=%b done=%b want 0/11/0", busyO, segDig, doneO); end
        bad_done = 0;
        repeat (80) begin
            tick(1'b0, 8'h00, 1'b0);
            if (doneO !== 1'b0 || busyO !== 1'b0) bad_done = 1;
        end
        n_checks++; if (bad_done) begin n_fail++; $display("FAIL abort_quiet got activity=1 want=0"); end
        tick(1'b1, 8'h02, 1'b0);
        repeat (7) tick(1'b0, 8'h00, 1'b0);
        tick(1'b1, 8'h02, 1'b0);
        n_checks++; if (busyO !== 1'b1 || doneO !== 1'b0 || segO2 !== pat(2)) begin
            n_fail++; $display("FAIL restart got busy=%b done=%b units=%h want 1/0/%h", busyO, doneO, segO2, pat(2)); end
        n = 0;
        while (doneO !== 1'b1 && n < 60) begin
            tick(1'b0, 8'h00, 1'b0);
            n++;
        end
        n_checks++; if (n != 20) begin n_fail++; $display("FAIL restart_period got=%0d want=20", n); end
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_midcount();
        bit bad;
        tick(1'b1, 8'h04, 1'b0);
        repeat (5) tick(1'b0, 8'h00, 1'b0);
        #3;
        rstnI = 1'b0;
        model_reset();
        #1;
        n_checks++; if (busyO !== 1'b0 || segDig !== 2'b11 || doneO !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid got busy=%b dig=%b done=%b want 0/11/0", busyO, segDig, doneO); end
        startI = 1'b1; secI = 8'h07;
        @(posedge clkI); #1;
        n_checks++; if (busyO !== 1'b0 || segO2 !== pat(0)) begin
            n_fail++; $display("FAIL rst_hold got busy=%b units=%h want 0/%h", busyO, segO2, pat(0)); end
        @(negedge clkI);
        rstnI = 1'b1;
        tick(1'b1, 8'h07, 1'b0);
        n_checks++; if (busyO !== 1'b1 || segO2 !== pat(7)) begin
            n_fail++; $display("FAIL rst_first_edge got busy=%b units=%h want 1/%h", busyO, segO2, pat(7)); end
        bad = 0;
        repeat (5) begin
            tick(1'b0, 8'h00, 1'b0);
            if (doneO !== 1'b0) bad = 1;
        end
        tick(1'b0, 8'h00, 1'b1);
        n_checks++; if (bad) begin n_fail++; $display("FAIL rst_no_done got done seen=1 want=0"); end
    endtask

    task automatic test_blink();
        bit bad;
        logic [1:0] want;
        tick(1'b1, 8'h05, 1'b0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick(1'b0, 8'h00, 1'b0);
            want = (BLINK && (k % 10) >= 5) ? 2'b11 : 2'b00;
            if (segDig !== want) begin
                bad = 1;
                $display("FAIL blink_k%0d got=%b want=%b", k, segDig, want);
            end
        end
        n_checks++; if (bad) n_fail++;
        tick(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] v;
        bit s, a;
        int r;
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 7);
            if (r == 0) v = 8'h00;
            else if (r == 1) v = {4'($urandom_range(10, 15)), 4'($urandom)};
            else v = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            s = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 24) == 0);
            tick(s, v, a);
            n_checks++; if (busyO !== (m_mode == 1)) begin
                n_fail++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busyO, (m_mode == 1)); end
            n_checks++; if (doneO !== (m_mode == 2)) begin
                n_fail++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, doneO, (m_mode == 2)); end
            n_checks++; if (segDig !== exp_dig()) begin
                n_fail++; $display("FAIL rnd_dig c=%0d got=%b want=%b", c, segDig, exp_dig()); end
            n_checks++; if (segO1 !== pat(m_mode == 1 ? m_secs / 10 : 0) || segO2 !== pat(m_mode == 1 ? m_secs % 10 : 0)) begin
                n_fail++; $display("FAIL rnd_seg c=%0d got=%h/%h want=%h/%h", c, segO1, segO2,
                    pat(m_mode == 1 ? m_secs / 10 : 0), pat(m_mode == 1 ? m_secs % 10 : 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_invalid();
        test_zero();
        test_abort();
        test_reset_midcount();
        test_blink();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
